// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stage bit positions,
// stall vector encodings, FSM states and the default exception vector.
package pipeline_ctrl_pkg;

    // Bit position of each pipeline hold in the stall vector
    localparam int STAGE_PC    = 0;
    localparam int STAGE_IFID  = 1;
    localparam int STAGE_IDEX  = 2;
    localparam int STAGE_EXMEM = 3;
    localparam int STAGE_MEMWB = 4;
    localparam int STAGE_WB    = 5;
    localparam int STALL_W     = STAGE_WB + 1;

    localparam logic        Stop     = 1'b1;
    localparam logic        NoStop   = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Hold every stage from the PC up to and including top_stage; the
    // boundary just above top_stage then inserts a bubble.
    function automatic logic [STALL_W-1:0] stall_upto(input int top_stage);
        logic [STALL_W-1:0] v;
        v = {STALL_W{NoStop}};
        for (int i = STAGE_PC; i < STALL_W; i++) begin
            if (i <= top_stage) v[i] = Stop;
        end
        return v;
    endfunction

    localparam logic [STALL_W-1:0] STALL_NONE = {STALL_W{NoStop}};
    localparam logic [STALL_W-1:0] STALL_ID   = stall_upto(STAGE_IDEX);   // 6'b000111
    localparam logic [STALL_W-1:0] STALL_EX   = stall_upto(STAGE_EXMEM);  // 6'b001111
    localparam logic [STALL_W-1:0] STALL_MEM  = stall_upto(STAGE_MEMWB);  // 6'b011111

    // The IF/ID hold is always part of any non-empty stall vector
    localparam logic STALL_IFID_IN_ID = STALL_ID[STAGE_IFID];

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Consecutive-stall watchdog: counts back-to-back stalled cycles and raises
// a sticky flag once the run reaches STALL_LIMIT.
module pipeline_ctrl_stall_watchdog #(
    parameter int STALL_LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active_i,
    input  logic flush_i,
    output logic timeout_o
);

    localparam int CW = $clog2(STALL_LIMIT) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // Next count: restart on any idle or flush cycle, saturate at the limit
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (flush_i || !stall_active_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == LIMIT) timeout_d = 1'b1;
    end

    // Counter and sticky flag registers; only reset clears the flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: derives the per-stage stall vector,
// sequences a one-cycle flush with PC redirect, and keeps stall statistics.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int          STALL_LIMIT = 1024,
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_req,
    input  logic        exc_is_eret,
    input  logic [31:0] epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic        stall_timeout
);

    state_e              state_q, state_d;
    logic [STALL_W-1:0]  stall_vec;
    logic                load_pc;
    logic [31:0]         new_pc_q, new_pc_d;
    logic [31:0]         stall_cycles_q;
    logic                stall_active;

    // State register; reset also aborts a flush in progress
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Next state and stall vector: deepest requesting stage wins in RUN,
    // nothing is held during FLUSH or while reset is asserted
    always_comb begin
        state_d   = state_q;
        stall_vec = STALL_NONE;
        load_pc   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (stallreq_mem)     stall_vec = STALL_MEM;
                else if (stallreq_ex) stall_vec = STALL_EX;
                else if (stallreq_id) stall_vec = STALL_ID;
                if (exc_req) begin
                    state_d = ST_FLUSH;
                    load_pc = 1'b1;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        if (rst) stall_vec = STALL_NONE;
    end

    assign new_pc_d     = exc_is_eret ? epc_i : EXC_VECTOR;
    assign stall_active = (stall_vec != STALL_NONE) && STALL_IFID_IN_ID;

    // Redirect target captured when the exception is accepted, held otherwise
    always_ff @(posedge clk) begin
        if (rst)          new_pc_q <= ZeroWord;
        else if (load_pc) new_pc_q <= new_pc_d;
    end

    // Free-running stalled-cycle counter, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst)               stall_cycles_q <= ZeroWord;
        else if (stall_active) stall_cycles_q <= stall_cycles_q + 32'd1;
    end

    pipeline_ctrl_stall_watchdog #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall_watchdog (
        .clk            (clk),
        .rst            (rst),
        .stall_active_i (stall_active),
        .flush_i        (flush),
        .timeout_o      (stall_timeout)
    );

    assign stall        = stall_vec;
    assign flush        = (state_q == ST_FLUSH);
    assign new_pc       = new_pc_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a cycle-level
// reference model derived from the controller's behavioural rules.
module tb_pipeline_ctrl;

    localparam int LIMIT = 8;

    logic        clk;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic        exc_req, exc_is_eret;
    logic [31:0] epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic        stall_timeout;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic        m_flush;
    logic [31:0] m_pc;
    logic [31:0] m_cyc;
    int          m_consec;
    logic        m_to;

    pipeline_ctrl #(
        .STALL_LIMIT (LIMIT),
        .EXC_VECTOR  (32'h0000_0020)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .exc_req       (exc_req),
        .exc_is_eret   (exc_is_eret),
        .epc_i         (epc_i),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_cycles  (stall_cycles),
        .stall_timeout (stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Number of stages held: a request holds its own stage and everything
    // upstream of it, i.e. mem holds 5 stages, ex 4, id 3.
    function automatic logic [5:0] ref_stall(input logic r, input logic fl,
                                             input logic id, input logic ex, input logic mem);
        int n;
        n = 0;
        if (!r && !fl) begin
            if (mem)     n = 5;
            else if (ex) n = 4;
            else if (id) n = 3;
        end
        return 6'((1 << n) - 1);
    endfunction

    // One clock cycle: drive at negedge, check just after, advance model at posedge
    task automatic step(input logic r, input logic id, input logic ex, input logic mem,
                        input logic exc, input logic eret, input logic [31:0] epc);
        logic [5:0] es;
        rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
        exc_req = exc; exc_is_eret = eret; epc_i = epc;
        #1;
        es = ref_stall(r, m_flush, id, ex, mem);
        chk("stall",         {26'd0, stall},         {26'd0, es});
        chk("flush",         {31'd0, flush},         {31'd0, m_flush});
        chk("new_pc",        new_pc,                 m_pc);
        chk("stall_cycles",  stall_cycles,           m_cyc);
        chk("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_to});
        @(posedge clk);
        if (r) begin
            m_flush = 1'b0; m_pc = 32'd0; m_cyc = 32'd0; m_consec = 0; m_to = 1'b0;
        end else begin
            if (es != 6'd0) m_cyc = m_cyc + 32'd1;
            if (m_flush || es == 6'd0) m_consec = 0;
            else if (m_consec < LIMIT) m_consec = m_consec + 1;
            if (m_consec == LIMIT) m_to = 1'b1;
            if (!m_flush && exc) begin
                m_pc    = eret ? epc : 32'h0000_0020;
                m_flush = 1'b1;
            end else begin
                m_flush = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        m_flush = 1'b0; m_pc = 32'd0; m_cyc = 32'd0; m_consec = 0; m_to = 1'b0;
        rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        exc_req = 1'b0; exc_is_eret = 1'b0; epc_i = 32'd0;
        @(negedge clk);

        // Reset with requests asserted: stall forced to zero
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("rst_new_pc", new_pc, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);

        // ID-only stall for three cycles
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        idle(1);
        chk("id3_cycles", stall_cycles, 32'd3);

        // All three requests, then mem dropped
        stallreq_id = 1'b1; stallreq_ex = 1'b1; stallreq_mem = 1'b1; #1;
        chk("all_req", {26'd0, stall}, 32'h1F);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        stallreq_mem = 1'b0; #1;
        chk("drop_mem", {26'd0, stall}, 32'h0F);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        idle(1);

        // Plain exception redirects to the vector for exactly one cycle
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("exc_flush", {31'd0, flush}, 32'd1);
        chk("exc_pc", new_pc, 32'h20);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("exc_unflush", {31'd0, flush}, 32'd0);
        idle(1);

        // ERET with EX stall held; repeated exception inside FLUSH ignored
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0040_0104);
        chk("eret_pc", new_pc, 32'h0040_0104);
        chk("eret_stall", {26'd0, stall}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1234);
        chk("eret_single", {31'd0, flush}, 32'd0);
        chk("eret_pc_hold", new_pc, 32'h0040_0104);
        idle(1);

        // Watchdog trips on the LIMIT-th consecutive stall edge
        for (int i = 0; i < LIMIT - 1; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("wd_before", {31'd0, stall_timeout}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("wd_trip", {31'd0, stall_timeout}, 32'd1);
        idle(2);
        chk("wd_sticky", {31'd0, stall_timeout}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("wd_rst", {31'd0, stall_timeout}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 1) == 1),
                 $urandom);
        end
        idle(1);

        // Stall counter wraps from all-ones to zero
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        m_cyc = 32'hFFFF_FFFF;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("wrap", stall_cycles, 32'd0);
        idle(1);

        // Reset in the middle of a flush
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("rstflush_flush", {31'd0, flush}, 32'd0);
        chk("rstflush_pc", new_pc, 32'd0);
        chk("rstflush_cyc", stall_cycles, 32'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter STALL_LIMIT, default 1024, consecutive-stall-cycle count that trips the watchdog.
REQ-002 Parameter EXC_VECTOR, default 32'h00000020, redirect PC for every non-ERET exception.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stallreq_id  in  1  ID-stage hazard stall request (load-use).
REQ-006 stallreq_ex  in  1  EX-stage multi-cycle stall request (mul/div).
REQ-007 stallreq_mem  in  1  MEM-stage data-bus wait request.
REQ-008 exc_req  in  1  exception committed in MEM this cycle.
REQ-009 exc_is_eret  in  1  qualifies exc_req as ERET.
REQ-010 epc_i  in  32  return address used for ERET.
REQ-011 stall  out  6  per-stage hold vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = Stop.
REQ-012 flush  out  1  one-cycle pipeline flush, all pipeline registers load zero.
REQ-013 new_pc  out  32  redirect address, valid only while flush=1.
REQ-014 stall_cycles  out  32  count of cycles with stall!=0.
REQ-015 stall_timeout  out  1  sticky watchdog flag.

Function
REQ-016 Two-state FSM: RUN, FLUSH.
REQ-017 RUN: stall is combinational from requests, priority mem > ex > id.
REQ-018 stallreq_mem=1 -> stall=6'b011111; else stallreq_ex=1 -> 6'b001111; else stallreq_id=1 -> 6'b000111; else 6'b000000.
REQ-019 Stage k is held while stage k+1 runs; the boundary register inserts a bubble (zero) — the pipeline-register contract.
REQ-020 RUN with exc_req=1 at edge N -> state FLUSH in cycle N+1; new_pc registered at edge N.
REQ-021 new_pc = epc_i if exc_is_eret, else EXC_VECTOR; exc_is_eret ignored when exc_req=0.
REQ-022 FLUSH: flush=1, stall=6'b000000 regardless of requests; lasts exactly one cycle, then RUN.
REQ-023 exc_req during FLUSH is ignored (no second flush, new_pc unchanged).
REQ-024 Exception in cycle N coexisting with stall requests: stall still driven per REQ-018 in cycle N; flush in N+1 overrides.
REQ-025 flush=0 in RUN; new_pc holds last value outside FLUSH.
REQ-026 stall_cycles increments by 1 each cycle stall!=0; wraps 32'hFFFFFFFF -> 0; no saturation.
REQ-027 Consecutive-stall counter increments while stall!=0, clears on any stall==0 cycle or flush; width ceil(log2(STALL_LIMIT))+1, saturates at STALL_LIMIT.
REQ-028 Counter reaching STALL_LIMIT sets stall_timeout=1 on that edge; stays 1 until rst; does not alter stall.

Reset
REQ-029 rst=1 at edge: state RUN, flush=0, new_pc=0, stall_cycles=0, consecutive counter=0, stall_timeout=0.
REQ-030 While rst=1, stall output forced 6'b000000.
REQ-031 rst during FLUSH aborts flush; flush=0 from the next cycle.

Structure
REQ-032 Stage bit indices, stall vector constants (STALL_NONE/ID/EX/MEM), FSM state encodings and EXC_VECTOR default go in the shared defines file alongside Stop/NoStop/ZeroWord.
REQ-033 One sub-module, stall_watchdog (consecutive counter + sticky flag); remainder flat.

Verification
REQ-034 stallreq_id=1 only, 3 cycles -> stall=6'b000111 each cycle, stall_cycles=3.
REQ-035 stallreq_id=stallreq_ex=stallreq_mem=1 -> stall=6'b011111; drop mem -> 6'b001111.
REQ-036 exc_req=1, exc_is_eret=0 at cycle 5 -> cycle 6 flush=1, new_pc=32'h20, stall=0; cycle 7 flush=0.
REQ-037 exc_req=1, exc_is_eret=1, epc_i=32'h00400104, stallreq_ex=1 held -> next cycle flush=1, new_pc=32'h00400104, stall=0; exc_req repeated in FLUSH -> single flush only.
REQ-038 STALL_LIMIT=8, stallreq_mem=1 for 8 cycles -> stall_timeout=1 after 8th edge, stays 1 after request drops; rst clears it.
REQ-039 Preload stall_cycles to 32'hFFFFFFFF via forced stall run, one more stall cycle -> 0; rst mid-FLUSH -> flush=0, all outputs at reset values.
